serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial adder that sits upstream of the single-bit full-adder cell and feeds it one operand bit pair per clock, LSB first.
- Holds the running carry in a flip-flop and assembles the sum in a shift register.
- Presents a WIDTH-bit sum plus carry-out with a start/busy/done handshake.
- Trades WIDTH+1 cycles of latency for one full-adder cell instead of a ripple chain.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request to begin an addition; acted on only in IDLE.
- a  input  WIDTH  operand A; sampled only on the accepted start edge.
- b  input  WIDTH  operand B; sampled only on the accepted start edge.
- cin  input  1  carry-in; sampled only on the accepted start edge.
- busy  output  1  high while bits are being processed (SHIFT state).
- done  output  1  one-cycle pulse: sum/cout are valid.
- sum  output  WIDTH  result register.
- cout  output  1  final carry-out register.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are clk and rst. All state changes on the rising edge of clk.
- Reset (rst=1 at an edge):
  - state <= IDLE; busy=0, done=0, sum=0, cout=0.
  - Operand shift registers, carry flip-flop and bit counter are cleared.
  - rst overrides start and any in-progress addition. A reset mid-SHIFT aborts with no done pulse.
- States: IDLE, SHIFT, DONE. The state is encoded in a 2-bit register; the unused code returns to IDLE on the next edge.
- IDLE:
  - busy=0, done=0; sum/cout hold their last result.
  - On an edge with start=1: load a_sr<=a, b_sr<=b, carry<=cin, count<=0, state<=SHIFT.
- SHIFT:
  - busy=1, done=0. Combinational full-adder inputs are a_sr[0], b_sr[0] and carry.
  - Each edge:
    - sum_sr <= {fa_sum, sum_sr[WIDTH-1:1]}
    - carry <= fa_cout
    - a_sr and b_sr shift right by one (zero fill)
    - count <= count+1
  - On the edge where count==WIDTH-1: state<=DONE. cout latches the fa_cout of that final bit.
  - The sum output reflects sum_sr. Intermediate values are partial and are not guaranteed meaningful while busy=1.
- DONE:
  - busy=0, done=1 for exactly one cycle; state<=IDLE on the next edge.
  - sum and cout then hold until the next accepted start.
- start is ignored in SHIFT and DONE; no queuing. Earliest back-to-back start is the first IDLE cycle after done.
- Latency: start accepted at edge k; busy high for cycles k+1..k+WIDTH; done high in cycle k+WIDTH+1.
- Arithmetic: {cout,sum} == a + b + cin, modulo 2^(WIDTH+1). Unsigned; no overflow flag.
- Counter width: clog2(WIDTH), minimum 1 bit.
- WIDTH=1: a single SHIFT cycle, then DONE.
- Simultaneous rst and start: rst wins, and the start is lost.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2
  - WIDTH legal-range limits (min 1, max 32)
- One sub-module: instantiate the existing fullAdder cell (ports cin, a, b, sum, cout) for the per-bit add. No other hierarchy.

Test Plan:
- Reset: hold rst 2 cycles with start=1 -> busy=0, done=0, sum=0x00, cout=0; no addition starts.
- WIDTH=8, a=0x5A, b=0x3C, cin=0, one-cycle start -> busy high exactly 8 cycles, then done pulse 1 cycle; sum=0x96, cout=0, held afterwards.
- Carry chains:
  - a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
  - a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
  - a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
- Start while busy:
  - Start 0x12+0x34; pulse start with a=0xAA, b=0x55 at busy cycle 3 -> ignored; done gives sum=0x46, cout=0.
  - Then start again in the first IDLE cycle after done -> accepted, sum=0xFF, cout=0.
- Reset mid-op: start 0x80+0x80, assert rst at busy cycle 5 -> next cycle busy=0, sum=0, cout=0; done never pulses.
- Random: 1000 random a/b/cin on WIDTH=8 and WIDTH=1 -> {cout,sum} matches a+b+cin every time; done-to-start gap ≥1 cycle.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: state encoding and WIDTH limits shared by the serial adder
package serial_adder_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 32;
endpackage

// File: rtl/serial_adder_fa.sv
// fullAdder: single-bit full-adder cell
//   cin, a, b : addend bits
//   sum, cout : sum bit and carry-out
module fullAdder (
    input  logic cin,
    input  logic a,
    input  logic b,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one full-adder cell, LSB first, WIDTH+1 cycle latency
//   clk, rst       : clock, synchronous active-high reset
//   start          : begin an addition (honoured only in IDLE)
//   a, b, cin      : operands and carry-in, captured on the accepted start
//   busy, done     : busy while shifting; done pulses one cycle with a valid result
//   sum, cout      : result registers, held until the next accepted start
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("serial_adder: WIDTH out of range");
    end
    state_t          state, state_nx;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic [CW-1:0]   count;
    logic            carry, fa_sum, fa_cout, last;
    fullAdder u_fa (
        .cin (carry),
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .sum (fa_sum),
        .cout(fa_cout)
    );
    assign last = count == CW'(WIDTH - 1);
    assign busy = state == SHIFT;
    assign done = state == DONE;
    // DONE and the unused code both fall to IDLE via the default
    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = start ? SHIFT : IDLE;
            SHIFT:   state_nx = last ? DONE : SHIFT;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            carry <= 1'b0;
            count <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                a_sr  <= a;
                b_sr  <= b;
                carry <= cin;
                count <= '0;
            end else if (state == SHIFT) begin
                // new sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts
                sum   <= (sum >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
                carry <= fa_cout;
                a_sr  <= a_sr >> 1;
                b_sr  <= b_sr >> 1;
                count <= count + CW'(1);
                if (last) cout <= fa_cout;
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: table, hand-written and random checks for WIDTH=8 and WIDTH=1
module tb_serial_adder;
    logic clk = 0, rst = 1;
    logic start8 = 0, cin8 = 0, start1 = 0, cin1 = 0;
    logic [7:0] a8 = 0, b8 = 0, sum8;
    logic a1 = 0, b1 = 0, sum1;
    logic busy8, done8, cout8, busy1, done1, cout1;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );
    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    typedef struct {
        logic [7:0] a, b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Launch one addition and wait (bounded) for done; returns busy cycle count and {cout,sum}.
    task automatic run(input bit w1, input logic [7:0] x, input logic [7:0] y, input logic c,
                       output int nb, output bit ok, output logic [8:0] res);
        @(negedge clk);
        if (w1) begin a1 = x[0]; b1 = y[0]; cin1 = c; start1 = 1; end
        else begin a8 = x; b8 = y; cin8 = c; start8 = 1; end
        @(negedge clk);
        start1 = 0; start8 = 0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
        nb = 0; ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (w1 ? done1 : done8) ok = 1;
            else begin
                if (w1 ? busy1 : busy8) nb++;
                @(negedge clk);
            end
        end
        res = w1 ? 9'({cout1, sum1}) : {cout8, sum8};
    endtask

    vec_t vt[5];
    int nb;
    bit ok;
    logic [8:0] res, exp;
    logic [7:0] x, y;
    logic c;

    initial begin
        vt[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vt[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vt[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vt[4] = '{8'hC3, 8'h3D, 1'b1, 8'h01, 1'b1};

        // reset held two cycles with start asserted
        start8 = 1; start1 = 1; a8 = 8'hFF; b8 = 8'hFF;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy8), 0);
        check("rst_done", 32'(done8), 0);
        check("rst_sum", 32'(sum8), 0);
        check("rst_cout", 32'(cout8), 0);
        check("rst_busy1", 32'(busy1), 0);
        rst = 0; start8 = 0; start1 = 0;
        @(negedge clk);
        check("post_rst_idle", 32'(busy8), 0);

        foreach (vt[i]) begin
            run(0, vt[i].a, vt[i].b, vt[i].cin, nb, ok, res);
            check($sformatf("vec%0d_done", i), 32'(ok), 1);
            check($sformatf("vec%0d_busy_cycles", i), nb, 8);
            check($sformatf("vec%0d_sum", i), 32'(res[7:0]), 32'(vt[i].sum));
            check($sformatf("vec%0d_cout", i), 32'(res[8]), 32'(vt[i].cout));
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), 32'(done8), 0);
            check($sformatf("vec%0d_hold", i), 32'({cout8, sum8}), 32'({vt[i].cout, vt[i].sum}));
        end

        // start pulsed while busy must be ignored; start held through done only takes in IDLE
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; cin8 = 0; start8 = 1;
        @(negedge clk);
        start8 = 0;
        @(negedge clk);
        @(negedge clk);
        a8 = 8'hAA; b8 = 8'h55; start8 = 1;
        @(negedge clk);
        start8 = 0;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) if (done8) ok = 1; else @(negedge clk);
        check("busy_start_done", 32'(ok), 1);
        check("busy_start_sum", 32'({cout8, sum8}), 32'h046);
        start8 = 1;
        @(negedge clk);
        check("start_in_done_ignored", 32'(busy8), 0);
        @(negedge clk);
        start8 = 0;
        check("b2b_accepted", 32'(busy8), 1);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) if (done8) ok = 1; else @(negedge clk);
        check("b2b_done", 32'(ok), 1);
        check("b2b_sum", 32'({cout8, sum8}), 32'h0FF);

        // reset during SHIFT aborts with no done pulse
        @(negedge clk);
        a8 = 8'h80; b8 = 8'h80; cin8 = 0; start8 = 1;
        @(negedge clk);
        start8 = 0;
        repeat (4) @(negedge clk);
        check("midrst_busy_before", 32'(busy8), 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("midrst_busy", 32'(busy8), 0);
        check("midrst_sum", 32'({cout8, sum8}), 0);
        ok = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) ok = 1;
        end
        check("midrst_no_done", 32'(ok), 0);

        // random against arithmetic model on both widths
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 1000; i++) begin
                x = 8'($urandom); y = 8'($urandom); c = 1'($urandom);
                exp = w ? 9'(x[0]) + 9'(y[0]) + 9'(c) : 9'(x) + 9'(y) + 9'(c);
                run(w[0], x, y, c, nb, ok, res);
                check($sformatf("rnd_w%0d_done", w ? 1 : 8), 32'(ok), 1);
                check($sformatf("rnd_w%0d_busy", w ? 1 : 8), nb, w ? 1 : 8);
                check($sformatf("rnd_w%0d_res a=%0h b=%0h c=%0d", w ? 1 : 8, x, y, c), 32'(res), 32'(exp));
                if (!ok) break;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
